// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Provides the FSM state type, default width and the counter-width helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..width-1, never less than one.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
// Purely combinational; the serial datapath instantiates it once.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, valid/ready on both sides.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = count_width(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;

  logic             d_s;
  logic             borrow_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  full_subtractor u_cell (
    .x    (a_sr_r[0]),
    .y    (b_sr_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (borrow_nxt_s)
  );

  assign res_nxt_s = {d_s, res_r[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  // On the final shift a_sr_r[0]/b_sr_r[0] hold the operand MSBs and d_s is the result MSB.
  logic ovf_s;
  assign ovf_s = (a_sr_r[0] != b_sr_r[0]) && (d_s != a_sr_r[0]);
`endif

  // Control FSM, shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= CNT_ZERO;
      a_sr_r      <= {WIDTH{1'b0}};
      b_sr_r      <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
      start_ready <= 1'b1;
      diff_out    <= {WIDTH{1'b0}};
      bout        <= 1'b0;
      done_valid  <= 1'b0;
      busy        <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_sr_r      <= a_in;
            b_sr_r      <= b_in;
            borrow_r    <= bin;
            count_r     <= CNT_ZERO;
            state_r     <= SHIFT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end else begin
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        SHIFT: begin
          res_r    <= res_nxt_s;
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          borrow_r <= borrow_nxt_s;
          count_r  <= count_r + CNT_ONE;
          if (count_r == CNT_LAST) begin
            state_r    <= DONE;
            diff_out   <= res_nxt_s;
            bout       <= borrow_nxt_s;
            done_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= ovf_s;
`endif
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          // start_ready comes from state only; done_ready never reaches it combinationally.
          if (done_valid && done_ready) begin
            state_r     <= IDLE;
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          start_ready <= 1'b1;
          done_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
// Covers ovf checks too when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance signals
  logic       sv8 = 1'b0, sr8, dv8, dr8 = 1'b0, busy8, bi8 = 1'b0, bo8;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, d8;
  // WIDTH=4 instance signals
  logic       sv4 = 1'b0, sr4, dv4, dr4 = 1'b1, busy4, bi4 = 1'b0, bo4;
  logic [3:0] a4 = 4'h0, b4 = 4'h0, d4;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf8, ovf4;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .bin(bi8), .diff_out(d8), .bout(bo8),
    .done_valid(dv8), .done_ready(dr8), .busy(busy8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .a_in(a4), .b_in(b4), .bin(bi4), .diff_out(d4), .bout(bo4),
    .done_valid(dv4), .done_ready(dr4), .busy(busy4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Launch one WIDTH=8 transaction and stop at the negedge where done_valid is first seen.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!sr8 && guard < 50) begin @(negedge clk); guard++; end
    a8 = a; b8 = b; bi8 = bi; sv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!dv8 && lat < 50);
    if (lat >= 50) begin
      total++; bad++;
      $display("FAIL launch8_timeout got no done_valid, need done_valid within 50 cycles");
    end
  endtask

  // Complete the result handshake on dut8 and return at the following negedge.
  task automatic ack8();
    dr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dr8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (sr8 !== 1'b1)   begin bad++; $display("FAIL rst_start_ready got %b need 1", sr8); end
    total++; if (d8 !== 8'h00)   begin bad++; $display("FAIL rst_diff got %h need 00", d8); end
    total++; if (bo8 !== 1'b0)   begin bad++; $display("FAIL rst_bout got %b need 0", bo8); end
    total++; if (dv8 !== 1'b0)   begin bad++; $display("FAIL rst_done_valid got %b need 0", dv8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b need 0", busy8); end
`ifdef SERIAL_SUB_OVF_EN
    total++; if (ovf8 !== 1'b0)  begin bad++; $display("FAIL rst_ovf got %b need 0", ovf8); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    launch8(8'h05, 8'h03, 1'b0, lat);
    total++; if (lat != 8)          begin bad++; $display("FAIL latency got %0d need 8", lat); end
    total++; if (d8 !== 8'h02)      begin bad++; $display("FAIL sub_05_03 diff got %h need 02", d8); end
    total++; if (bo8 !== 1'b0)      begin bad++; $display("FAIL sub_05_03 bout got %b need 0", bo8); end
    total++; if (busy8 !== 1'b1)    begin bad++; $display("FAIL busy_in_done got %b need 1", busy8); end
`ifdef SERIAL_SUB_OVF_EN
    total++; if (ovf8 !== 1'b0)     begin bad++; $display("FAIL sub_05_03 ovf got %b need 0", ovf8); end
`endif
    ack8();
    launch8(8'h03, 8'h05, 1'b0, lat);
    total++; if (d8 !== 8'hFE)      begin bad++; $display("FAIL sub_03_05 diff got %h need FE", d8); end
    total++; if (bo8 !== 1'b1)      begin bad++; $display("FAIL sub_03_05 bout got %b need 1", bo8); end
    ack8();
    launch8(8'h00, 8'h00, 1'b1, lat);
    total++; if (d8 !== 8'hFF)      begin bad++; $display("FAIL sub_00_00_b1 diff got %h need FF", d8); end
    total++; if (bo8 !== 1'b1)      begin bad++; $display("FAIL sub_00_00_b1 bout got %b need 1", bo8); end
    ack8();
  endtask

  task automatic test_boundary();
    int lat;
    launch8(8'h5A, 8'h5A, 1'b1, lat);
    total++; if (d8 !== 8'hFF)      begin bad++; $display("FAIL a_eq_b_b1 diff got %h need FF", d8); end
    total++; if (bo8 !== 1'b1)      begin bad++; $display("FAIL a_eq_b_b1 bout got %b need 1", bo8); end
    ack8();
    launch8(8'h00, 8'hFF, 1'b1, lat);
    total++; if (d8 !== 8'h00)      begin bad++; $display("FAIL zero_minus_ff_b1 diff got %h need 00", d8); end
    total++; if (bo8 !== 1'b1)      begin bad++; $display("FAIL zero_minus_ff_b1 bout got %b need 1", bo8); end
    ack8();
  endtask

  task automatic test_backpressure();
    int lat;
    launch8(8'h05, 8'h03, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      sv8 = i[0] ? 1'b0 : 1'b1;
      a8 = 8'hAA; b8 = 8'h11; bi8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if (d8 !== 8'h02)   begin bad++; $display("FAIL bp_diff cyc%0d got %h need 02", i, d8); end
      total++; if (bo8 !== 1'b0)   begin bad++; $display("FAIL bp_bout cyc%0d got %b need 0", i, bo8); end
      total++; if (sr8 !== 1'b0)   begin bad++; $display("FAIL bp_start_ready cyc%0d got %b need 0", i, sr8); end
      total++; if (dv8 !== 1'b1)   begin bad++; $display("FAIL bp_done_valid cyc%0d got %b need 1", i, dv8); end
    end
    sv8 = 1'b0;
    ack8();
    total++; if (sr8 !== 1'b1)     begin bad++; $display("FAIL bp_release_start_ready got %b need 1", sr8); end
    total++; if (dv8 !== 1'b0)     begin bad++; $display("FAIL bp_release_done_valid got %b need 0", dv8); end
    total++; if (busy8 !== 1'b0)   begin bad++; $display("FAIL bp_release_busy got %b need 0", busy8); end
    @(posedge clk);
    @(negedge clk);
    total++; if (busy8 !== 1'b0)   begin bad++; $display("FAIL bp_no_capture_busy got %b need 0", busy8); end
    total++; if (d8 !== 8'h02)     begin bad++; $display("FAIL bp_no_capture_diff got %h need 02", d8); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    @(negedge clk);
    a8 = 8'h37; b8 = 8'h12; bi8 = 1'b0; sv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (busy8 !== 1'b1)   begin bad++; $display("FAIL midshift_busy got %b need 1", busy8); end
    rst_n = 1'b0;
    #1;
    total++; if (sr8 !== 1'b1)     begin bad++; $display("FAIL midrst_start_ready got %b need 1", sr8); end
    total++; if (d8 !== 8'h00)     begin bad++; $display("FAIL midrst_diff got %h need 00", d8); end
    total++; if (bo8 !== 1'b0)     begin bad++; $display("FAIL midrst_bout got %b need 0", bo8); end
    total++; if (dv8 !== 1'b0)     begin bad++; $display("FAIL midrst_done_valid got %b need 0", dv8); end
    total++; if (busy8 !== 1'b0)   begin bad++; $display("FAIL midrst_busy got %b need 0", busy8); end
    @(negedge clk);
    rst_n = 1'b1;
    launch8(8'h10, 8'h01, 1'b0, lat);
    total++; if (lat != 8)         begin bad++; $display("FAIL post_rst_latency got %0d need 8", lat); end
    total++; if (d8 !== 8'h0F)     begin bad++; $display("FAIL post_rst_diff got %h need 0F", d8); end
    total++; if (bo8 !== 1'b0)     begin bad++; $display("FAIL post_rst_bout got %b need 0", bo8); end
    ack8();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    launch8(8'h80, 8'h01, 1'b0, lat);
    total++; if (d8 !== 8'h7F)     begin bad++; $display("FAIL ovf_80_01 diff got %h need 7F", d8); end
    total++; if (ovf8 !== 1'b1)    begin bad++; $display("FAIL ovf_80_01 ovf got %b need 1", ovf8); end
    ack8();
    launch8(8'h7F, 8'hFF, 1'b0, lat);
    total++; if (d8 !== 8'h80)     begin bad++; $display("FAIL ovf_7f_ff diff got %h need 80", d8); end
    total++; if (ovf8 !== 1'b1)    begin bad++; $display("FAIL ovf_7f_ff ovf got %b need 1", ovf8); end
    ack8();
  endtask
`endif

  // Exhaustive WIDTH=4 sweep with done_ready held high so transactions run back to back.
  task automatic test_back_to_back();
    int e, sa, sb, guard;
    logic [3:0] exp_d;
    logic exp_bo;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          guard = 0;
          while (!sr4 && guard < 50) begin @(negedge clk); guard++; end
          a4 = 4'(a); b4 = 4'(b); bi4 = 1'(bi); sv4 = 1'b1;
          @(posedge clk);
          @(negedge clk);
          sv4 = 1'b0;
          guard = 0;
          while (!dv4 && guard < 50) begin @(negedge clk); guard++; end
          e = a - b - bi;
          exp_d = 4'(e);
          exp_bo = (e < 0);
          total++;
          if (d4 !== exp_d || guard >= 50) begin
            bad++; $display("FAIL sweep_diff a=%0d b=%0d bin=%0d got %h need %h", a, b, bi, d4, exp_d);
          end
          total++;
          if (bo4 !== exp_bo) begin
            bad++; $display("FAIL sweep_bout a=%0d b=%0d bin=%0d got %b need %b", a, b, bi, bo4, exp_bo);
          end
`ifdef SERIAL_SUB_OVF_EN
          sa = (a >= 8) ? a - 16 : a;
          sb = (b >= 8) ? b - 16 : b;
          total++;
          if (ovf4 !== ((sa - sb - bi) < -8 || (sa - sb - bi) > 7)) begin
            bad++; $display("FAIL sweep_ovf a=%0d b=%0d bin=%0d got %b", a, b, bi, ovf4);
          end
`else
          sa = 0; sb = 0;
`endif
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_reset_mid_shift();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse counterpart of the team's full-adder datapath, giving the arithmetic block set a subtract path.
- Operands are accepted and results returned over valid/ready handshakes, so it drops into streaming datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  operands valid.
- start_ready  out  1  block can accept operands.
- a_in  in  WIDTH  minuend.
- b_in  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- diff_out  out  WIDTH  difference.
- bout  out  1  borrow-out (1 means a < b + bin, unsigned).
- done_valid  out  1  result valid.
- done_ready  in  1  consumer accepts result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low (rst_n), all flops cleared on assertion.
- Reset values: start_ready=1, diff_out=0, bout=0, done_valid=0, busy=0. State is IDLE, count=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready at the edge: load a_sr=a_in, b_sr=b_in, borrow=bin, count=0, go to SHIFT.
- SHIFT:
  - start_ready=0.
  - Each cycle:
    - d = a_sr[0]^b_sr[0]^borrow.
    - borrow' = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
    - result shifts right with d entering the MSB.
    - a_sr and b_sr shift right.
    - count increments.
  - At the edge where count==WIDTH-1: go to DONE, latch bout=borrow', diff_out=final result.
- DONE:
  - done_valid=1. diff_out and bout are held stable while done_ready=0.
  - On done_valid&&done_ready: go to IDLE and clear done_valid.
  - diff_out and bout keep their last value until the next completion.
- Latency: done_valid rises exactly WIDTH clocks after the accept edge. One full transaction is WIDTH+1 cycles minimum, plus one IDLE cycle before the next accept.
- start_ready is a registered/state decode only, with no combinational path from done_ready. start_valid in SHIFT or DONE is ignored, and operands are not sampled.
- Arithmetic: modulo 2^WIDTH, unsigned borrow semantics.
- Boundary cases:
  - a==b, bin=1 gives diff all ones, bout=1.
  - a=0, b=all ones, bin=1 gives diff=0, bout=1.
- Reset mid-operation (SHIFT or DONE) aborts immediately to reset values. The partial result is discarded.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), which flags signed two's-complement overflow of a - b - bin.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), computed from the MSBs captured during the final SHIFT cycle.
  - Latched with bout, valid under done_valid, reset 0.
- Undefined: the port is absent and no overflow logic is built.

Decomposition:
- Package serial_sub_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - the count-width helper $clog2(WIDTH).
- One sub-module, full_subtractor (x, y, bin -> d, bout), purely combinational. It is instantiated once for the per-bit cell.

Test Plan:
- 0x05 - 0x03, bin=0: diff_out=0x02, bout=0, done_valid exactly 8 cycles after accept.
- 0x03 - 0x05, bin=0: diff_out=0xFE, bout=1. Also 0x00 - 0x00, bin=1: diff_out=0xFF, bout=1.
- Backpressure: hold done_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands:
  - diff_out and bout stay stable;
  - start_ready stays 0;
  - new operands are not captured;
  - after the handshake, start_ready=1 on the next cycle.
- Reset mid-SHIFT: assert rst_n=0 at count 4. All outputs read reset values immediately (asynchronously). After release, a fresh 0x10 - 0x01 yields 0x0F.
- Exhaustive WIDTH=4 sweep of all a, b, bin with back-to-back transactions, checked against a - b - bin mod 16 and borrow. With SERIAL_SUB_OVF_EN defined, the WIDTH=8 case 0x80 - 0x01 gives diff_out=0x7F, ovf=1, and 0x7F - 0xFF gives diff_out=0x80, ovf=1.
